// File: rtl/psram_pkg.sv
// Shared constants for the PSRAM command-port arbiter: FSM encoding and defaults.
// The timeout default is derived from the controller access latency.
package psram_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ISSUED = 2'd1;
  localparam state_t ST_WAIT   = 2'd2;

  localparam int PSRAM_AW      = 22;
  localparam int PSRAM_LATENCY = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Slowest access (read) plus one cycle of margin before declaring the controller stuck.
  localparam int PSRAM_TIMEOUT = max_int(5 + 2 * PSRAM_LATENCY, 10 + 2 * PSRAM_LATENCY) + 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester scanning upward from i_last+1 with wrap.
// Zero latency; o_vld low when nobody requests.
module rr_pick #(
  parameter int NPORTS = 2,
  parameter int GW     = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] i_req,
  input  logic [GW-1:0]     i_last,
  output logic [GW-1:0]     o_win,
  output logic              o_vld
);

  always_comb begin
    int v_idx;
    o_win = '0;
    o_vld = 1'b0;
    v_idx = 0;
    // Scan from the farthest candidate down so the nearest requester overrides.
    for (int k = NPORTS; k >= 1; k--) begin
      v_idx = (int'(i_last) + k) % NPORTS;
      if (i_req[v_idx[GW-1:0]]) begin
        o_win = v_idx[GW-1:0];
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one PsramController command port; command one cycle after req.
// Holds off while mem_busy is high; aborts with ack+err after TIMEOUT cycles of busy.
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int NPORTS  = 2,
  parameter int AW      = PSRAM_AW,
  parameter int TIMEOUT = PSRAM_TIMEOUT,
  parameter int TW      = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NPORTS-1:0]          req,
  input  logic [NPORTS-1:0]          we,
  input  logic [NPORTS-1:0]          byte_we,
  input  logic [NPORTS*AW-1:0]       addr,
  input  logic [NPORTS*16-1:0]       wdata,
  output logic [NPORTS-1:0]          ack,
  output logic                       err,
  output logic [15:0]                rdata,
  output logic [7:0]                 rdata_byte,
  output logic [$clog2(NPORTS)-1:0]  grant,
  output logic                       timeout_sticky,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic                       mem_byte_write,
  output logic [AW-1:0]              mem_addr,
  output logic [15:0]                mem_din,
  input  logic [15:0]                mem_dout,
  input  logic                       mem_busy
);

  localparam int GW = $clog2(NPORTS);

  state_t            r_state, w_next;
  logic [TW-1:0]     r_cnt;
  logic [GW-1:0]     r_last, r_grant, w_win;
  logic              r_we, r_a0, w_vld;
  logic [NPORTS-1:0] r_ack;
  logic              r_err, r_sticky, r_mem_read, r_mem_write, r_mem_bw;
  logic [15:0]       r_rdata, r_mem_din;
  logic [7:0]        r_rdata_byte;
  logic [AW-1:0]     r_mem_addr;
  logic              w_issue, w_done, w_tout, w_fin, w_we, w_bw;
  logic [AW-1:0]     w_addr;
  logic [15:0]       w_wd;

  rr_pick #(.NPORTS(NPORTS), .GW(GW)) u_pick (
    .i_req  (req),
    .i_last (r_last),
    .o_win  (w_win),
    .o_vld  (w_vld)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_issue) w_next = ST_ISSUED;
      ST_ISSUED: w_next = ST_WAIT;
      ST_WAIT:   if (w_fin) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_we    = we[w_win];
    w_bw    = byte_we[w_win];
    w_addr  = addr[int'(w_win)*AW +: AW];
    w_wd    = wdata[int'(w_win)*16 +: 16];
    w_issue = (r_state == ST_IDLE) && !mem_busy && w_vld;
    w_done  = (r_state == ST_WAIT) && !mem_busy;
    // Busy is ignored in ISSUED: the controller raises it one cycle after the pulse.
    w_tout  = (r_state == ST_WAIT) && mem_busy && (r_cnt == TW'(TIMEOUT));
    w_fin   = w_done || w_tout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_last       <= GW'(NPORTS - 1);
      r_grant      <= '0;
      r_we         <= 1'b0;
      r_a0         <= 1'b0;
      r_ack        <= '0;
      r_err        <= 1'b0;
      r_sticky     <= 1'b0;
      r_rdata      <= '0;
      r_rdata_byte <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_bw     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
    end else begin
      r_mem_read  <= w_issue && !w_we;
      r_mem_write <= w_issue && w_we;
      r_mem_bw    <= w_issue && w_we && w_bw;
      r_ack       <= '0;
      r_err       <= 1'b0;
      if (w_issue) begin
        r_grant    <= w_win;
        r_we       <= w_we;
        r_a0       <= w_addr[0];
        r_mem_addr <= w_addr;
        r_mem_din  <= w_bw ? {w_wd[7:0], w_wd[7:0]} : w_wd;
      end
      if (r_state == ST_ISSUED) r_cnt <= TW'(1);
      else if (w_fin)           r_cnt <= '0;
      else if (r_state == ST_WAIT) r_cnt <= r_cnt + 1'b1;
      if (w_fin) begin
        r_ack[r_grant] <= 1'b1;
        r_last         <= r_grant;
      end
      if (w_done && !r_we) begin
        r_rdata      <= mem_dout;
        r_rdata_byte <= r_a0 ? mem_dout[15:8] : mem_dout[7:0];
      end
      if (w_tout) begin
        r_err    <= 1'b1;
        r_sticky <= 1'b1;
      end
    end
  end

  assign ack            = r_ack;
  assign err            = r_err;
  assign rdata          = r_rdata;
  assign rdata_byte     = r_rdata_byte;
  assign grant          = r_grant;
  assign timeout_sticky = r_sticky;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_byte_write = r_mem_bw;
  assign mem_addr       = r_mem_addr;
  assign mem_din        = r_mem_din;

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Shares the single PsramController command port between NPORTS requesters, e.g. a test engine, a video fetch and a CPU bus.
- Picks one requester at a time by round-robin and issues one single-cycle read/write pulse.
- Tracks the controller's busy handshake through to completion, returns read data and a per-port ack.
- Flags a timeout if the controller never completes.
- Sits between the requesters and PsramController, in the same clock domain.

Parameters:
- NPORTS, 2, number of requesters (2..4).
- AW, 22, word/byte address width passed to the controller.
- TIMEOUT, 31, cycles allowed from command pulse to busy deasserting before aborting.
- TW, 5, width of the timeout counter; must satisfy TIMEOUT < 2**TW.

Ports:
- clk  in  1  controller clock (same as PsramController clk).
- reset  in  1  asynchronous, active-high reset.
- req  in  NPORTS  per-port request; held high until that port's ack.
- we  in  NPORTS  1=write, 0=read; sampled with req.
- byte_we  in  NPORTS  byte-granular write.
- addr  in  NPORTS*AW  per-port address, port i at [i*AW +: AW].
- wdata  in  NPORTS*16  per-port write data, port i at [i*16 +: 16].
- ack  out  NPORTS  one-cycle completion pulse to the granted port.
- err  out  1  one-cycle pulse coincident with ack when the access timed out.
- rdata  out  16  read word; held until the next read completes.
- rdata_byte  out  8  rdata[15:8] if latched addr[0] is 1, else rdata[7:0].
- grant  out  $clog2(NPORTS)  index of the current/last granted port.
- timeout_sticky  out  1  set on any timeout; cleared only by reset.
- mem_read, mem_write, mem_byte_write  out  1  controller command pulses.
- mem_addr  out  AW  controller address.
- mem_din  out  16  controller write data.
- mem_dout  in  16  controller read data.
- mem_busy  in  1  controller busy.

Behaviour:
- Reset values: all outputs are 0; state is IDLE; the round-robin pointer selects port 0 first; counter is 0.
- All outputs are registered.
- State machine: IDLE -> ISSUED -> WAIT -> IDLE.
- IDLE:
  - If mem_busy=0 and any req=1, select the winner: first requesting port scanning from (last_grant+1) mod NPORTS upward with wrap.
  - Latch we, byte_we, addr and wdata of the winner. Drive exactly one of mem_read/mem_write high for one cycle.
  - mem_byte_write = byte_we of the winner, for writes only.
  - Set grant and go to ISSUED.
  - While mem_busy=1 (controller still initialising, or finishing an access aborted by reset), no command is issued.
- Latency: req rising in IDLE with mem_busy=0 -> command pulse on the next clk edge.
- Byte writes: mem_din = {wdata[7:0], wdata[7:0]}. Word writes: mem_din = wdata.
- ISSUED: command pulse deasserts; counter=1; unconditionally go to WAIT. mem_busy is not sampled here because the controller raises busy one cycle after the pulse.
- WAIT: counter increments each cycle.
  - On mem_busy=0: pulse ack[grant]; for reads, register rdata<=mem_dout; update last_grant=grant; go to IDLE.
  - If counter==TIMEOUT and mem_busy still 1: pulse ack[grant] and err; set timeout_sticky; rdata unchanged; go to IDLE. IDLE then waits for mem_busy=0.
- A new grant can issue no earlier than the cycle after ack. Back-to-back accesses are therefore at least 3 cycles plus the controller busy time.
- Simultaneous requests: serviced strictly in round-robin order. A continuously requesting port waits at most NPORTS-1 accesses.
- req dropped before ack: a protocol violation. The access still completes and ack still pulses.
- Port inputs are ignored except in IDLE. Changes to a port's addr/wdata while it is granted have no effect.
- Reset mid-access: all state clears immediately. Pending requesters must hold req and are re-arbitrated after mem_busy falls.

Decomposition:
- Shared package (psram_pkg) holds:
  - the state encoding localparams ST_IDLE/ST_ISSUED/ST_WAIT;
  - the default AW=22;
  - a TIMEOUT default derived from LATENCY (5+LATENCY*2 for writes, 10+LATENCY*2 for reads; use the larger).
- One natural sub-module, rr_pick: combinational round-robin selector with inputs req and last_grant and outputs a winner index and a valid flag. Unit-testable in isolation.

Test Plan:
- Single read: port0 req=1, we=0, addr=22'h000123, controller model busy for 12 cycles, mem_dout=16'hA55A -> mem_read pulse one cycle after req, mem_addr=22'h000123, ack[0] on busy fall, rdata=16'hA55A, rdata_byte=8'hA5.
- Byte write: port1 req=1, we=1, byte_we=1, wdata=16'h00C3 -> mem_write and mem_byte_write pulse together, mem_din=16'hC3C3, ack[1], err=0.
- Contention: port0 and port1 both request continuously for 6 accesses -> grant sequence 0,1,0,1,0,1; each ack goes only to the granted port; no two command pulses are fewer than 3 cycles apart.
- Init gating: mem_busy held 1 for 50 cycles after reset with port0 requesting -> no command pulse until mem_busy=0, then exactly one mem_read.
- Timeout: controller holds busy after a write with TIMEOUT=31 -> ack[0] and err pulse on cycle 31 after the pulse, timeout_sticky=1, and no new command until busy drops.
- Reset mid-access: assert reset in WAIT -> all outputs are 0 the same cycle; after release and busy=0, the still-requesting port is re-issued once and acked.
